// File: rtl/debug_cmd_engine_pkg.sv
// Shared opcode/reply byte codes and FSM state encoding for the debug command engine.
package debug_cmd_engine_pkg;

    localparam logic [7:0] OP_STOP  = 8'h53;
    localparam logic [7:0] OP_GO    = 8'h47;
    localparam logic [7:0] OP_READ  = 8'h52;
    localparam logic [7:0] OP_WRITE = 8'h57;

    localparam logic [7:0] RSP_OK   = 8'h4B;
    localparam logic [7:0] RSP_ERR  = 8'h45;
    localparam logic [7:0] RSP_UNK  = 8'h3F;
    localparam logic [7:0] RSP_TMO  = 8'h54;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARG,
        ST_BUSREQ,
        ST_RESP
    } state_t;

endpackage

// File: rtl/debug_cmd_engine_timeout_ctr.sv
// Loadable 8-bit down-counter with terminal-count flag; bounds the busInterface wait.
module debug_timeout_ctr (
    input  logic       clk,
    input  logic       reset,
    input  logic       load,
    input  logic [7:0] load_val,
    input  logic       en,
    output logic       tc
);

    logic [7:0] count;

    always_ff @(posedge clk) begin
        if (reset)
            count <= '0;
        else if (load)
            count <= load_val;
        else if (en && count != 8'd0)
            count <= count - 8'd1;
    end

    assign tc = (count == 8'd0);

endmodule

// File: rtl/debug_cmd_engine.sv
// Byte-serial debug command engine: parses host bytes, halts/releases the CPU and
// issues single 16-bit debug reads/writes through busInterface.
module debug_cmd_engine
    import debug_cmd_engine_pkg::*;
#(
    parameter int TIMEOUT = 255
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_VALID,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    input  logic        TX_READY,
    output logic        DEBUG_DEBUG,
    output logic        DEBUG_STOP,
    output logic [15:0] DEBUG_ADDR,
    output logic [15:0] DEBUG_DOUT,
    output logic        DEBUG_REQ_RD,
    output logic        DEBUG_REQ_WR,
    input  logic        DEBUG_RD,
    input  logic        DEBUG_WR,
    input  logic [15:0] DEBUG_DIN
);

    localparam logic [7:0] TMO_LOAD = 8'(TIMEOUT);

    state_t      state, state_n;
    logic [1:0]  arg_cnt, arg_cnt_n;
    logic        is_wr, is_wr_n;
    logic        second, second_n;
    logic [15:0] resp, resp_n;
    logic [7:0]  tx_data_n;
    logic        tx_valid_n;
    logic        stop_n, debug_n;
    logic [15:0] addr_n, dout_n;
    logic        req_rd_n, req_wr_n;
    logic        tmo_load, tmo_tc;
    logic        last_arg, strobe_hit;

    debug_timeout_ctr u_tmo (
        .clk      (CLK),
        .reset    (RESET),
        .load     (tmo_load),
        .load_val (TMO_LOAD),
        .en       (state == ST_BUSREQ),
        .tc       (tmo_tc)
    );

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state        <= ST_IDLE;
            arg_cnt      <= '0;
            is_wr        <= 1'b0;
            second       <= 1'b0;
            resp         <= '0;
            TX_DATA      <= '0;
            TX_VALID     <= 1'b0;
            DEBUG_STOP   <= 1'b0;
            DEBUG_DEBUG  <= 1'b0;
            DEBUG_ADDR   <= '0;
            DEBUG_DOUT   <= '0;
            DEBUG_REQ_RD <= 1'b0;
            DEBUG_REQ_WR <= 1'b0;
        end else begin
            state        <= state_n;
            arg_cnt      <= arg_cnt_n;
            is_wr        <= is_wr_n;
            second       <= second_n;
            resp         <= resp_n;
            TX_DATA      <= tx_data_n;
            TX_VALID     <= tx_valid_n;
            DEBUG_STOP   <= stop_n;
            DEBUG_DEBUG  <= debug_n;
            DEBUG_ADDR   <= addr_n;
            DEBUG_DOUT   <= dout_n;
            DEBUG_REQ_RD <= req_rd_n;
            DEBUG_REQ_WR <= req_wr_n;
        end
    end

    assign last_arg   = is_wr ? (arg_cnt == 2'd3) : (arg_cnt == 2'd1);
    assign strobe_hit = is_wr ? DEBUG_WR : DEBUG_RD;

    always_comb begin
        state_n    = state;
        arg_cnt_n  = arg_cnt;
        is_wr_n    = is_wr;
        second_n   = second;
        resp_n     = resp;
        tx_data_n  = TX_DATA;
        tx_valid_n = TX_VALID;
        stop_n     = DEBUG_STOP;
        debug_n    = DEBUG_DEBUG;
        addr_n     = DEBUG_ADDR;
        dout_n     = DEBUG_DOUT;
        req_rd_n   = DEBUG_REQ_RD;
        req_wr_n   = DEBUG_REQ_WR;
        tmo_load   = 1'b0;

        case (state)
            ST_IDLE: begin
                if (RX_VALID) begin
                    second_n = 1'b0;
                    arg_cnt_n = '0;
                    case (RX_DATA)
                        OP_STOP: begin
                            stop_n     = 1'b1;
                            debug_n    = 1'b1;
                            tx_data_n  = RSP_OK;
                            tx_valid_n = 1'b1;
                            state_n    = ST_RESP;
                        end
                        OP_GO: begin
                            stop_n     = 1'b0;
                            debug_n    = 1'b0;
                            tx_data_n  = RSP_OK;
                            tx_valid_n = 1'b1;
                            state_n    = ST_RESP;
                        end
                        OP_READ: begin
                            is_wr_n = 1'b0;
                            state_n = ST_ARG;
                        end
                        OP_WRITE: begin
                            is_wr_n = 1'b1;
                            state_n = ST_ARG;
                        end
                        default: begin
                            tx_data_n  = RSP_UNK;
                            tx_valid_n = 1'b1;
                            state_n    = ST_RESP;
                        end
                    endcase
                end
            end

            ST_ARG: begin
                if (RX_VALID) begin
                    case (arg_cnt)
                        2'd0:    addr_n[15:8] = RX_DATA;
                        2'd1:    addr_n[7:0]  = RX_DATA;
                        2'd2:    dout_n[15:8] = RX_DATA;
                        default: dout_n[7:0]  = RX_DATA;
                    endcase
                    arg_cnt_n = arg_cnt + 2'd1;
                    if (last_arg) begin
                        if (DEBUG_STOP) begin
                            req_rd_n = ~is_wr;
                            req_wr_n = is_wr;
                            tmo_load = 1'b1;
                            state_n  = ST_BUSREQ;
                        end else begin
                            tx_data_n  = RSP_ERR;
                            tx_valid_n = 1'b1;
                            state_n    = ST_RESP;
                        end
                    end
                end
            end

            ST_BUSREQ: begin
                // Strobe is checked before the terminal count so it wins a tie.
                if (strobe_hit) begin
                    req_rd_n   = 1'b0;
                    req_wr_n   = 1'b0;
                    tx_valid_n = 1'b1;
                    state_n    = ST_RESP;
                    if (is_wr) begin
                        tx_data_n = RSP_OK;
                    end else begin
                        resp_n    = DEBUG_DIN;
                        tx_data_n = DEBUG_DIN[15:8];
                        second_n  = 1'b1;
                    end
                end else if (tmo_tc) begin
                    req_rd_n   = 1'b0;
                    req_wr_n   = 1'b0;
                    tx_data_n  = RSP_TMO;
                    tx_valid_n = 1'b1;
                    state_n    = ST_RESP;
                end
            end

            ST_RESP: begin
                if (TX_VALID && TX_READY) begin
                    if (second) begin
                        tx_data_n = resp[7:0];
                        second_n  = 1'b0;
                    end else begin
                        tx_valid_n = 1'b0;
                        state_n    = ST_IDLE;
                    end
                end
            end

            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_debug_cmd_engine.sv
// Scoreboard bench for debug_cmd_engine: expected TX bytes are queued by the
// stimulus and popped by a monitor on every TX handshake.
module tb_debug_cmd_engine;

    logic        CLK = 1'b0;
    logic        RESET = 1'b1;
    logic [7:0]  RX_DATA = '0;
    logic        RX_VALID = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        TX_READY = 1'b1;
    logic        DEBUG_DEBUG, DEBUG_STOP;
    logic [15:0] DEBUG_ADDR, DEBUG_DOUT;
    logic        DEBUG_REQ_RD, DEBUG_REQ_WR;
    logic        DEBUG_RD = 1'b0;
    logic        DEBUG_WR = 1'b0;
    logic [15:0] DEBUG_DIN = '0;

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_q[$];

    debug_cmd_engine #(.TIMEOUT(8)) dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .RX_DATA      (RX_DATA),
        .RX_VALID     (RX_VALID),
        .TX_DATA      (TX_DATA),
        .TX_VALID     (TX_VALID),
        .TX_READY     (TX_READY),
        .DEBUG_DEBUG  (DEBUG_DEBUG),
        .DEBUG_STOP   (DEBUG_STOP),
        .DEBUG_ADDR   (DEBUG_ADDR),
        .DEBUG_DOUT   (DEBUG_DOUT),
        .DEBUG_REQ_RD (DEBUG_REQ_RD),
        .DEBUG_REQ_WR (DEBUG_REQ_WR),
        .DEBUG_RD     (DEBUG_RD),
        .DEBUG_WR     (DEBUG_WR),
        .DEBUG_DIN    (DEBUG_DIN)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: the handshake completes on the next rising edge.
    always @(negedge CLK) begin
        if (!RESET && TX_VALID && TX_READY) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL tx_unexpected: got 0x%0h, expected no byte", TX_DATA);
            end else begin
                check("tx_byte", {24'd0, TX_DATA}, {24'd0, exp_q.pop_front()});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        RX_DATA  = b;
        RX_VALID = 1'b1;
        @(negedge CLK);
        RX_VALID = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((TX_VALID || exp_q.size() != 0) && n < 60) begin
            @(negedge CLK);
            n++;
        end
        if (n >= 60) check("idle_timeout", 32'd1, 32'd0);
        @(negedge CLK);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_tx_valid"}, {31'd0, TX_VALID}, 32'd0);
        check({tag, "_tx_data"}, {24'd0, TX_DATA}, 32'd0);
        check({tag, "_stop_debug"}, {30'd0, DEBUG_STOP, DEBUG_DEBUG}, 32'd0);
        check({tag, "_addr_dout"}, {DEBUG_ADDR, DEBUG_DOUT}, 32'd0);
        check({tag, "_reqs"}, {30'd0, DEBUG_REQ_RD, DEBUG_REQ_WR}, 32'd0);
    endtask

    initial begin
        int k;
        repeat (3) @(negedge CLK);
        RESET = 1'b0;
        check_reset_outputs("reset");

        // Halt
        exp_q.push_back(8'h4B);
        send_byte(8'h53);
        check("s_stop_debug", {30'd0, DEBUG_STOP, DEBUG_DEBUG}, 32'd3);
        check("s_tx_valid", {31'd0, TX_VALID}, 32'd1);
        wait_idle();

        // Release
        exp_q.push_back(8'h4B);
        send_byte(8'h47);
        check("g_stop_debug", {30'd0, DEBUG_STOP, DEBUG_DEBUG}, 32'd0);
        wait_idle();

        // Read while running: error, no request
        exp_q.push_back(8'h45);
        send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
        check("r_run_req", {30'd0, DEBUG_REQ_RD, DEBUG_REQ_WR}, 32'd0);
        wait_idle();

        // Unknown opcode
        exp_q.push_back(8'h3F);
        send_byte(8'h00);
        check("unk_tx_valid", {31'd0, TX_VALID}, 32'd1);
        wait_idle();

        // Halt, then read 0x1234 returning 0xBEEF
        exp_q.push_back(8'h4B);
        send_byte(8'h53);
        wait_idle();
        exp_q.push_back(8'hBE);
        exp_q.push_back(8'hEF);
        send_byte(8'h52); send_byte(8'h12); send_byte(8'h34);
        check("r_addr", {16'd0, DEBUG_ADDR}, 32'h1234);
        for (int i = 0; i < 3; i++) begin
            check("r_req_held", {30'd0, DEBUG_REQ_RD, DEBUG_REQ_WR}, 32'd2);
            @(negedge CLK);
        end
        DEBUG_WR = 1'b1;   // mismatched strobe must be ignored
        @(negedge CLK);
        DEBUG_WR = 1'b0;
        check("r_wrong_strobe", {30'd0, DEBUG_REQ_RD, TX_VALID}, 32'd2);
        DEBUG_RD  = 1'b1;
        DEBUG_DIN = 16'hBEEF;
        @(negedge CLK);
        DEBUG_RD  = 1'b0;
        DEBUG_DIN = 16'h0000;
        check("r_req_drop", {30'd0, DEBUG_REQ_RD, TX_VALID}, 32'd1);
        wait_idle();

        // Write 0x4444 to 0x5555 with backpressure on the reply
        exp_q.push_back(8'h4B);
        send_byte(8'h57); send_byte(8'h55); send_byte(8'h55); send_byte(8'h44);
        TX_READY = 1'b0;
        send_byte(8'h44);
        check("w_addr_dout", {DEBUG_ADDR, DEBUG_DOUT}, 32'h5555_4444);
        check("w_req", {30'd0, DEBUG_REQ_RD, DEBUG_REQ_WR}, 32'd1);
        @(negedge CLK);
        DEBUG_WR = 1'b1;
        @(negedge CLK);
        DEBUG_WR = 1'b0;
        check("w_req_drop", {31'd0, DEBUG_REQ_WR}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            check("w_hold", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'h4B});
            @(negedge CLK);
        end
        TX_READY = 1'b1;
        wait_idle();

        // Read with no strobe: timeout reply TIMEOUT+1 cycles after the request
        exp_q.push_back(8'h54);
        send_byte(8'h52); send_byte(8'hAB); send_byte(8'hCD);
        check("t_req_up", {31'd0, DEBUG_REQ_RD}, 32'd1);
        k = 0;
        while (!TX_VALID && k < 20) begin
            @(negedge CLK);
            k++;
        end
        check("t_latency", k, 32'd9);
        check("t_req_drop", {31'd0, DEBUG_REQ_RD}, 32'd0);
        check("t_still_stopped", {30'd0, DEBUG_STOP, DEBUG_DEBUG}, 32'd3);
        wait_idle();

        // Strobe on the final timeout cycle wins
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        send_byte(8'h52); send_byte(8'h00); send_byte(8'h10);
        repeat (8) @(negedge CLK);
        DEBUG_RD  = 1'b1;
        DEBUG_DIN = 16'hA55A;
        @(negedge CLK);
        DEBUG_RD  = 1'b0;
        check("tie_tx", {23'd0, TX_VALID, TX_DATA}, {23'd0, 1'b1, 8'hA5});
        wait_idle();

        // Reset in the middle of a write
        send_byte(8'h57); send_byte(8'h11); send_byte(8'h22); send_byte(8'h33);
        check("mid_w_addr", {16'd0, DEBUG_ADDR}, 32'h1122);
        RESET = 1'b1;
        @(negedge CLK);
        RESET = 1'b0;
        check_reset_outputs("midreset");
        exp_q.push_back(8'h4B);
        send_byte(8'h53);
        check("post_s_stop", {30'd0, DEBUG_STOP, DEBUG_DEBUG}, 32'd3);
        wait_idle();

        check("queue_drained", exp_q.size(), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete, expected finish");
        $fatal(1);
    end

endmodule
